// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared types and constants for the SCRISC-16 fetch stage.
package fetch_sequencer_pkg;

  localparam int unsigned PC_W = 16;

  typedef logic [PC_W-1:0] pc_t;

  localparam pc_t DEF_RESET_PC  = 16'h0000;
  localparam pc_t DEF_NOP_INSTR = 16'h0000;

  // Fetch FSM states.
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Which next-PC source won the priority selection this cycle.
  typedef enum logic [2:0] {
    SEL_BRANCH = 3'd0,
    SEL_JUMP   = 3'd1,
    SEL_SEQ    = 3'd2,
    SEL_WAIT   = 3'd3,
    SEL_HOLD   = 3'd4
  } sel_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction-memory req/ack bus between the fetch stage
// (master) and instruction memory (slave).
interface fetch_sequencer_if;
  import fetch_sequencer_pkg::*;

  logic imem_req;
  pc_t  imem_addr;
  logic imem_ack;
  pc_t  imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data
  );

endinterface

// File: rtl/fetch_sequencer_next_pc_mux.sv
// fetch_sequencer_next_pc_mux: combinational next-PC priority select and
// sequential increment (modulo 2^16).
module fetch_sequencer_next_pc_mux
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned PC_INC = 1
) (
  input  pc_t  pc,
  input  logic take,
  input  pc_t  br_target,
  input  logic jmp_valid,
  input  pc_t  jmp_target,
  input  logic stall,
  input  logic req,
  input  logic ack,
  output pc_t  pc_next,
  output sel_e sel
);

  // Priority: taken branch, jump (not under stall), acked fetch, wait, hold.
  always_comb begin
    pc_next = pc;
    sel     = SEL_HOLD;
    if (take) begin
      pc_next = br_target;
      sel     = SEL_BRANCH;
    end else if (jmp_valid && !stall) begin
      pc_next = jmp_target;
      sel     = SEL_JUMP;
    end else if (req && ack && !stall) begin
      pc_next = pc + pc_t'(PC_INC);
      sel     = SEL_SEQ;
    end else if (req && !ack) begin
      sel     = SEL_WAIT;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: SCRISC-16 instruction fetch / PC sequencing stage.
// Owns the PC, drives the imem req/ack bus, registers the IF/ID slot and
// raises flush strobes on a taken branch.
// Optional macro FETCH_BRANCH_STATS_EN adds saturating branch counters.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter pc_t         RESET_PC  = DEF_RESET_PC,
  parameter int unsigned PC_INC    = 1,
  parameter pc_t         NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      br_valid,
  input  logic                      check,
  input  pc_t                       br_target,
  input  logic                      jmp_valid,
  input  pc_t                       jmp_target,
  input  logic                      stall,
  fetch_sequencer_if.master         imem,
  output logic                      if_valid,
  output pc_t                       if_instr,
  output pc_t                       if_pc,
  output logic                      flush_id,
`ifdef FETCH_BRANCH_STATS_EN
  output logic [15:0]               br_taken_cnt,
  output logic [15:0]               br_total_cnt,
`endif
  output logic                      flush_ex
);

  state_e state_q, state_d;
  pc_t    pc_q, pc_d;
  logic   if_valid_q, if_valid_d;
  pc_t    if_instr_q, if_instr_d;
  pc_t    if_pc_q, if_pc_d;

  logic   take;
  logic   req;
  sel_e   sel;
  pc_t    pc_next;

  // Branch decision, fetch request and flush strobes.
  always_comb begin
    take     = br_valid & check;
    req      = (state_q == ST_RUN) & ~stall & ~rst;
    flush_id = take & ~rst;
    flush_ex = take & ~rst;
  end

  fetch_sequencer_next_pc_mux #(
    .PC_INC (PC_INC)
  ) u_next_pc_mux (
    .pc         (pc_q),
    .take       (take),
    .br_target  (br_target),
    .jmp_valid  (jmp_valid),
    .jmp_target (jmp_target),
    .stall      (stall),
    .req        (req),
    .ack        (imem.imem_ack),
    .pc_next    (pc_next),
    .sel        (sel)
  );

  // Next state of FSM, PC and IF/ID slot.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_next;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;

    if (take) begin
      state_d = ST_RUN;
    end else begin
      unique case (state_q)
        ST_BOOT: state_d = ST_RUN;
        ST_RUN:  if (stall) state_d = ST_HOLD;
        ST_HOLD: if (!stall) state_d = ST_RUN;
        default: state_d = ST_BOOT;
      endcase
    end

    unique case (sel)
      SEL_BRANCH, SEL_JUMP, SEL_WAIT: begin
        if_valid_d = 1'b0;
        if_instr_d = NOP_INSTR;
      end
      SEL_SEQ: begin
        if_valid_d = 1'b1;
        if_instr_d = imem.imem_data;
        if_pc_d    = pc_q;
      end
      default: ;
    endcase
  end

  // State, PC and IF/ID registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_instr_q <= NOP_INSTR;
      if_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;
  assign if_valid       = if_valid_q;
  assign if_instr       = if_instr_q;
  assign if_pc          = if_pc_q;

`ifdef FETCH_BRANCH_STATS_EN
  logic [15:0] br_taken_cnt_q, br_taken_cnt_d;
  logic [15:0] br_total_cnt_q, br_total_cnt_d;

  // Saturating branch statistics.
  always_comb begin
    br_taken_cnt_d = br_taken_cnt_q;
    br_total_cnt_d = br_total_cnt_q;
    if (br_valid && (br_total_cnt_q != '1)) br_total_cnt_d = br_total_cnt_q + 16'd1;
    if (take && (br_taken_cnt_q != '1))     br_taken_cnt_d = br_taken_cnt_q + 16'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_taken_cnt_q <= '0;
      br_total_cnt_q <= '0;
    end else begin
      br_taken_cnt_q <= br_taken_cnt_d;
      br_total_cnt_q <= br_total_cnt_d;
    end
  end

  assign br_taken_cnt = br_taken_cnt_q;
  assign br_total_cnt = br_total_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed vector bench for fetch_sequencer.
// Memory model returns imem_data = imem_addr + 16'h1000 with a driven ack.
module tb_fetch_sequencer;

  localparam logic [15:0] N = 16'hDEAD;

  logic        clk;
  logic        rst;
  logic        br_valid;
  logic        check;
  logic [15:0] br_target;
  logic        jmp_valid;
  logic [15:0] jmp_target;
  logic        stall;
  logic        ack_r;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        flush_id;
  logic        flush_ex;
`ifdef FETCH_BRANCH_STATS_EN
  logic [15:0] br_taken_cnt;
  logic [15:0] br_total_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  fetch_sequencer_if bus ();

  assign bus.imem_ack  = ack_r;
  assign bus.imem_data = bus.imem_addr + 16'h1000;

  fetch_sequencer #(
    .RESET_PC  (16'h0000),
    .PC_INC    (1),
    .NOP_INSTR (N)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .br_valid     (br_valid),
    .check        (check),
    .br_target    (br_target),
    .jmp_valid    (jmp_valid),
    .jmp_target   (jmp_target),
    .stall        (stall),
    .imem         (bus.master),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .flush_id     (flush_id),
`ifdef FETCH_BRANCH_STATS_EN
    .br_taken_cnt (br_taken_cnt),
    .br_total_cnt (br_total_cnt),
`endif
    .flush_ex     (flush_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst;
    logic        bv;
    logic        chk;
    logic [15:0] bt;
    logic        jv;
    logic [15:0] jt;
    logic        st;
    logic        ack;
    logic        req;
    logic [15:0] addr;
    logic        fl;
    logic        v;
    logic [15:0] instr;
    logic [15:0] ipc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, bv, ck, input logic [15:0] bt, input logic jv,
                     input logic [15:0] jt, input logic st, ak, rq, input logic [15:0] ad,
                     input logic fl, vl, input logic [15:0] ins, ip);
    vec_t t;
    t.rst = r; t.bv = bv; t.chk = ck; t.bt = bt; t.jv = jv; t.jt = jt;
    t.st = st; t.ack = ak; t.req = rq; t.addr = ad; t.fl = fl; t.v = vl;
    t.instr = ins; t.ipc = ip;
    vecs.push_back(t);
  endtask

  task automatic chk16(input string nm, input int row, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input int row, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %b expected %b", nm, row, act, exp);
    end
  endtask

  task automatic drive(input logic r, bv, ck, input logic [15:0] bt, input logic jv,
                       input logic [15:0] jt, input logic st, ak);
    rst = r; br_valid = bv; check = ck; br_target = bt;
    jmp_valid = jv; jmp_target = jt; stall = st; ack_r = ak;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);

    //   rst bv ck bt        jv jt        st ak | req addr      fl v  instr     ipc
    add(1, 1, 1, 16'h0777, 0, 16'h0000, 0, 1,   0, 16'h0000, 0, 0, N,        16'h0000);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1,   0, 16'h0000, 0, 0, N,        16'h0000);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1,   1, 16'h0000, 0, 0, N,        16'h0000);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1,   1, 16'h0001, 0, 1, 16'h1000, 16'h0000);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1,   1, 16'h0002, 0, 1, 16'h1001, 16'h0001);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1,   1, 16'h0003, 0, 1, 16'h1002, 16'h0002);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1,   1, 16'h0004, 0, 1, 16'h1003, 16'h0003);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0,   1, 16'h0005, 0, 1, 16'h1004, 16'h0004);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0,   1, 16'h0005, 0, 0, N,        16'h0004);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0,   1, 16'h0005, 0, 0, N,        16'h0004);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1,   1, 16'h0005, 0, 0, N,        16'h0004);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1,   0, 16'h0006, 0, 1, 16'h1005, 16'h0005);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1,   0, 16'h0006, 0, 1, 16'h1005, 16'h0005);
    add(0, 1, 1, 16'h0010, 0, 16'h0000, 1, 1,   0, 16'h0006, 1, 1, 16'h1005, 16'h0005);
    add(0, 1, 1, 16'h0040, 0, 16'h0000, 0, 1,   1, 16'h0010, 1, 0, N,        16'h0005);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1,   1, 16'h0040, 0, 0, N,        16'h0005);
    add(0, 1, 0, 16'h0999, 0, 16'h0000, 0, 1,   1, 16'h0041, 0, 1, 16'h1040, 16'h0040);
    add(0, 0, 0, 16'h0000, 1, 16'h0100, 0, 1,   1, 16'h0042, 0, 1, 16'h1041, 16'h0041);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1,   1, 16'h0100, 0, 0, N,        16'h0041);
    add(0, 0, 0, 16'h0000, 1, 16'h0300, 1, 1,   0, 16'h0101, 0, 1, 16'h1100, 16'h0100);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1,   0, 16'h0101, 0, 1, 16'h1100, 16'h0100);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1,   1, 16'h0101, 0, 1, 16'h1100, 16'h0100);
    add(0, 1, 1, 16'h0200, 1, 16'h0300, 0, 1,   1, 16'h0102, 1, 1, 16'h1101, 16'h0101);
    add(0, 1, 1, 16'hFFFF, 0, 16'h0000, 0, 1,   1, 16'h0200, 1, 0, N,        16'h0101);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1,   1, 16'hFFFF, 0, 0, N,        16'h0101);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1,   1, 16'h0000, 0, 1, 16'h0FFF, 16'hFFFF);
    add(0, 1, 1, 16'h0123, 0, 16'h0000, 0, 1,   1, 16'h0001, 1, 1, 16'h1000, 16'h0000);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0,   1, 16'h0123, 0, 0, N,        16'h0000);
    add(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0,   0, 16'h0123, 0, 0, N,        16'h0000);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1,   0, 16'h0000, 0, 0, N,        16'h0000);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1,   1, 16'h0000, 0, 0, N,        16'h0000);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].bv, vecs[i].chk, vecs[i].bt,
            vecs[i].jv, vecs[i].jt, vecs[i].st, vecs[i].ack);
      #1;
      chk1 ("imem_req",  i, bus.imem_req,  vecs[i].req);
      chk16("imem_addr", i, bus.imem_addr, vecs[i].addr);
      chk1 ("flush_id",  i, flush_id,      vecs[i].fl);
      chk1 ("flush_ex",  i, flush_ex,      vecs[i].fl);
      chk1 ("if_valid",  i, if_valid,      vecs[i].v);
      chk16("if_instr",  i, if_instr,      vecs[i].instr);
      chk16("if_pc",     i, if_pc,         vecs[i].ipc);
    end

    // Reset asserted mid-stall, with a taken branch present: reset wins.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1);
    #1;
    chk1 ("stall_req",   100, bus.imem_req,  1'b0);
    chk16("stall_addr",  100, bus.imem_addr, 16'h0001);
    chk16("stall_instr", 100, if_instr,      16'h1000);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 16'h0555, 1'b0, 16'h0, 1'b1, 1'b1);
    #1;
    chk1 ("rst_flush_id", 101, flush_id,     1'b0);
    chk1 ("rst_flush_ex", 101, flush_ex,     1'b0);
    chk1 ("rst_req",      101, bus.imem_req, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
    #1;
    chk1 ("boot_req",   102, bus.imem_req,  1'b0);
    chk16("boot_addr",  102, bus.imem_addr, 16'h0000);
    chk1 ("boot_valid", 102, if_valid,      1'b0);
    chk16("boot_instr", 102, if_instr,      N);
    @(negedge clk);
    #1;
    chk1 ("run_req",  103, bus.imem_req,  1'b1);
    chk16("run_addr", 103, bus.imem_addr, 16'h0000);

`ifdef FETCH_BRANCH_STATS_EN
    // Five branches, two taken, then a reset clears both counters.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
    #1;
    chk16("total_clr0", 200, br_total_cnt, 16'd0);
    chk16("taken_clr0", 200, br_taken_cnt, 16'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, (k == 0 || k == 3), 16'h0020, 1'b0, 16'h0, 1'b0, 1'b1);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
    #1;
    chk16("total_cnt", 201, br_total_cnt, 16'd5);
    chk16("taken_cnt", 201, br_taken_cnt, 16'd2);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 16'h0020, 1'b0, 16'h0, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
    #1;
    chk16("total_clr", 202, br_total_cnt, 16'd0);
    chk16("taken_clr", 202, br_taken_cnt, 16'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
